// File: rtl/serdes_apb_pkg.sv
// serdes_apb_pkg: init table, poll target and FSM types shared by the APB init/command master
package serdes_apb_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_EVAL, ST_READY} state_t;
  typedef enum logic [1:0] {M_INIT, M_POLL, M_USER} mode_t;
  typedef struct packed {
    logic        write;
    logic [13:2] addr;
    logic [31:0] data;
  } init_entry_t;
  localparam int INIT_LEN = 2;
  // word addresses: byte 0x010 <= 0x1, byte 0x020 <= 0xA5
  localparam init_entry_t INIT_TABLE [INIT_LEN] = '{
    '{1'b1, 12'h004, 32'h0000_0001},
    '{1'b1, 12'h008, 32'h0000_00A5}
  };
  localparam logic [13:2] POLL_ADDR = 12'h00C;
  localparam logic [31:0] POLL_MASK = 32'h0000_0001;
  // indices past the table yield the status read used by the lock poll
  function automatic init_entry_t load_entry(input int i);
    load_entry = '{1'b0, POLL_ADDR, 32'h0};
    for (int k = 0; k < INIT_LEN; k++) if (i == k) load_entry = INIT_TABLE[k];
  endfunction
endpackage

// File: rtl/serdes_apb_master.sv
// serdes_apb_master: APB master that runs an init table, polls for lock, then serves user commands
module serdes_apb_master
  import serdes_apb_pkg::*;
#(
  parameter int TIMEOUT    = 256,
  parameter int POLL_LIMIT = 1024
) (
  input  logic        APB_M_PCLK,
  input  logic        APB_M_PRESET,
  input  logic        START,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WRITE,
  input  logic [13:2] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        INIT_DONE,
  output logic        INIT_FAIL,
  output logic        APB_M_PSEL,
  output logic        APB_M_PENABLE,
  output logic        APB_M_PWRITE,
  output logic [13:2] APB_M_PADDR,
  output logic [31:0] APB_M_PWDATA,
  input  logic [31:0] APB_M_PRDATA,
  input  logic        APB_M_PREADY,
  input  logic        APB_M_PSLVERR
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  state_t      state_q, state_d;
  mode_t       mode_q, mode_d;
  logic [7:0]  idx_q, idx_d, nxt;
  logic [TW-1:0] wait_q, wait_d;
  logic [PW-1:0] poll_q, poll_d;
  logic        write_q, write_d;
  logic [13:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    poll_d  = poll_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    done_d  = done_q;
    fail_d  = fail_q;
    nxt     = idx_q + 8'd1;
    case (state_q)
      ST_IDLE: if (START) begin
        {write_d, addr_d, wdata_d} = load_entry(0);
        mode_d  = (INIT_LEN == 0) ? M_POLL : M_INIT;
        idx_d   = '0;
        poll_d  = '0;
        state_d = ST_SETUP;
      end
      ST_SETUP: begin
        wait_d  = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: if (APB_M_PREADY) begin
        rdata_d = write_q ? 32'h0 : APB_M_PRDATA;
        err_d   = APB_M_PSLVERR;
        state_d = ST_EVAL;
      end else if (wait_q == TW'(TIMEOUT - 1)) begin
        rdata_d = 32'h0;
        err_d   = 1'b1;
        state_d = ST_EVAL;
      end else begin
        wait_d = wait_q + TW'(1);
      end
      ST_EVAL: if (mode_q == M_USER) begin
        state_d = ST_READY;
      end else if (err_q) begin
        fail_d  = 1'b1;
        state_d = ST_READY;
      end else if (mode_q == M_INIT) begin
        idx_d   = nxt;
        {write_d, addr_d, wdata_d} = load_entry(int'(nxt));
        mode_d  = (int'(nxt) >= INIT_LEN) ? M_POLL : M_INIT;
        state_d = ST_SETUP;
      end else if ((rdata_q & POLL_MASK) == POLL_MASK) begin
        done_d  = 1'b1;
        state_d = ST_READY;
      end else if (poll_q == PW'(POLL_LIMIT - 1)) begin
        fail_d  = 1'b1;
        state_d = ST_READY;
      end else begin
        poll_d  = poll_q + PW'(1);
        state_d = ST_SETUP;
      end
      ST_READY: if (CMD_VALID) begin
        write_d = CMD_WRITE;
        addr_d  = CMD_ADDR;
        wdata_d = CMD_WDATA;
        mode_d  = M_USER;
        state_d = ST_SETUP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge APB_M_PCLK or posedge APB_M_PRESET) begin
    if (APB_M_PRESET) begin
      state_q <= ST_IDLE;
      mode_q  <= M_INIT;
      idx_q   <= '0;
      wait_q  <= '0;
      poll_q  <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      poll_q  <= poll_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign CMD_READY     = state_q == ST_READY;
  assign RSP_VALID     = state_q == ST_EVAL && mode_q == M_USER;
  assign RSP_RDATA     = RSP_VALID ? rdata_q : 32'h0;
  assign RSP_ERR       = RSP_VALID & err_q;
  assign INIT_DONE     = done_q;
  assign INIT_FAIL     = fail_q;
  assign APB_M_PSEL    = state_q == ST_SETUP || state_q == ST_ACCESS;
  assign APB_M_PENABLE = state_q == ST_ACCESS;
  assign APB_M_PWRITE  = write_q;
  assign APB_M_PADDR   = addr_q;
  assign APB_M_PWDATA  = wdata_q;
endmodule

// File: tb/tb_serdes_apb_master.sv
// tb_serdes_apb_master: APB slave model plus transfer scoreboard for the init/poll/command master
module tb_serdes_apb_master;
  import serdes_apb_pkg::POLL_ADDR;
  localparam int TB_TIMEOUT = 16;
  localparam int TB_POLL_LIMIT = 8;
  typedef struct {
    bit          wr;
    logic [13:2] addr;
    logic [31:0] data;
  } xfer_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [13:2] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic rsp_valid, rsp_err, init_done, init_fail;
  logic [31:0] rsp_rdata;
  logic psel, penable, pwrite;
  logic [13:2] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic pready = 1'b0, pslverr = 1'b0;
  int tests = 0, fails = 0;
  int wait_states = 0, match_at = 0, err_wr = -1;
  bit stuck = 0;
  logic [31:0] user_rdata = '0;
  int n_wr = 0, n_rd = 0, acc_cyc = 0, last_acc_len = 0;
  bit was_acc = 0;
  logic s_wr;
  logic [13:2] s_addr;
  logic [31:0] s_wd;
  xfer_t exp_q[$];
  xfer_t mx;
  bit exp_done, exp_fail;
  logic [13:2] tbl_addr [2] = '{12'h004, 12'h008};
  logic [31:0] tbl_data [2] = '{32'h1, 32'hA5};

  serdes_apb_master #(.TIMEOUT(TB_TIMEOUT), .POLL_LIMIT(TB_POLL_LIMIT)) dut (
    .APB_M_PCLK(clk), .APB_M_PRESET(rst), .START(start),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
    .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .INIT_DONE(init_done), .INIT_FAIL(init_fail),
    .APB_M_PSEL(psel), .APB_M_PENABLE(penable), .APB_M_PWRITE(pwrite),
    .APB_M_PADDR(paddr), .APB_M_PWDATA(pwdata),
    .APB_M_PRDATA(prdata), .APB_M_PREADY(pready), .APB_M_PSLVERR(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
  endtask

  // Expected APB traffic of an init run: table writes, then status reads until match or limit
  task automatic plan_init(input int match, input int err);
    exp_done = 0;
    exp_fail = 0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{1'b1, tbl_addr[i], tbl_data[i]});
      if (i == err) begin
        exp_fail = 1;
        return;
      end
    end
    exp_done = match >= 1 && match <= TB_POLL_LIMIT;
    exp_fail = !exp_done;
    for (int i = 0; i < (exp_done ? match : TB_POLL_LIMIT); i++) exp_q.push_back('{1'b0, POLL_ADDR, 32'h0});
  endtask

  // Slave model and scoreboard: sampled and driven on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      was_acc = 0;
      acc_cyc = 0;
      pready = 0;
      prdata = 0;
      pslverr = 0;
    end else begin
      chk("penable_without_psel", penable & ~psel, 0);
      chk("done_fail_exclusive", init_done & init_fail, 0);
      if (was_acc && !penable) begin
        last_acc_len = acc_cyc;
        if (s_wr) n_wr++; else n_rd++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer: got wr=%0d addr=%h, required no transfer", s_wr, s_addr);
        end else begin
          mx = exp_q.pop_front();
          chk("xfer_dir", s_wr, mx.wr);
          chk("xfer_addr", s_addr, mx.addr);
          if (mx.wr) chk("xfer_wdata", s_wd, mx.data);
        end
      end
      if (psel && !penable) begin
        s_addr = paddr;
        s_wr = pwrite;
        s_wd = pwdata;
      end
      if (psel && penable) begin
        chk("stable_paddr", paddr, s_addr);
        chk("stable_pwrite", pwrite, s_wr);
        chk("stable_pwdata", pwdata, s_wd);
        pready = !stuck && acc_cyc >= wait_states;
        prdata = (!pwrite && paddr == POLL_ADDR) ?
                 ((match_at != 0 && n_rd + 1 == match_at) ? 32'h1 : 32'hFFFF_FFFE) : user_rdata;
        pslverr = pwrite && n_wr == err_wr;
        acc_cyc++;
      end else begin
        pready = 0;
        prdata = 0;
        pslverr = 0;
        acc_cyc = 0;
      end
      was_acc = psel && penable;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    n_wr = 0;
    n_rd = 0;
    stuck = 0;
    wait_states = 0;
    match_at = 0;
    err_wr = -1;
    rst = 0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_init();
    int k = 0;
    while (!(init_done || init_fail) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("init_finished_in_bound", k < 400, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_cmd(input logic wr, input logic [13:2] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    chk("cmd_ready_before", cmd_ready, 1);
    cmd_valid = 1;
    cmd_write = wr;
    cmd_addr = a;
    cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 0);
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    logic er;
    int k;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_init_fail", init_fail, 0);
    chk("rst_psel", psel, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("idle_no_cmd_ready", cmd_ready, 0);
    // init: two writes, lock on third status read
    match_at = 3;
    plan_init(3, -1);
    start_pulse();
    wait_init();
    chk("s1_done", init_done, exp_done);
    chk("s1_fail", init_fail, exp_fail);
    chk("s1_done_lit", init_done, 1);
    chk("s1_writes", n_wr, 2);
    chk("s1_reads", n_rd, 3);
    chk("s1_all_seen", exp_q.size(), 0);
    chk("s1_cmd_ready", cmd_ready, 1);
    // START outside IDLE must not restart anything
    start_pulse();
    repeat (10) @(negedge clk);
    chk("start_ignored_wr", n_wr, 2);
    chk("start_ignored_rd", n_rd, 3);
    chk("start_ignored_done", init_done, 1);
    // user read, three wait states
    wait_states = 3;
    user_rdata = 32'hDEADBEEF;
    exp_q.push_back('{1'b0, 12'h040, 32'h0});
    do_cmd(1'b0, 12'h040, 32'h0, lat, rd, er);
    chk("rd_latency", lat, 6);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", er, 0);
    chk("rd_access_len", last_acc_len, 4);
    // user write, PREADY high
    wait_states = 0;
    exp_q.push_back('{1'b1, 12'h055, 32'hCAFEF00D});
    do_cmd(1'b1, 12'h055, 32'hCAFEF00D, lat, rd, er);
    chk("wr_latency", lat, 3);
    chk("wr_rdata_zero", rd, 0);
    chk("wr_err", er, 0);
    chk("idle_paddr_held", paddr, 12'h055);
    chk("idle_pwdata_held", pwdata, 32'hCAFEF00D);
    // PREADY stuck low
    stuck = 1;
    exp_q.push_back('{1'b0, 12'h077, 32'h0});
    do_cmd(1'b0, 12'h077, 32'h0, lat, rd, er);
    chk("to_access_len", last_acc_len, TB_TIMEOUT);
    chk("to_latency", lat, 18);
    chk("to_err", er, 1);
    chk("to_rdata", rd, 0);
    chk("to_psel_low", psel, 0);
    stuck = 0;
    // status never matches
    do_reset();
    chk("sticky_done_cleared", init_done, 0);
    plan_init(0, -1);
    start_pulse();
    wait_init();
    chk("s4_fail", init_fail, exp_fail);
    chk("s4_fail_lit", init_fail, 1);
    chk("s4_done", init_done, 0);
    chk("s4_reads", n_rd, 8);
    chk("s4_writes", n_wr, 2);
    chk("s4_all_seen", exp_q.size(), 0);
    chk("s4_cmd_ready", cmd_ready, 1);
    // slave error on init entry 1
    do_reset();
    err_wr = 1;
    plan_init(0, 1);
    start_pulse();
    wait_init();
    chk("s5_fail", init_fail, 1);
    chk("s5_done", init_done, 0);
    chk("s5_writes", n_wr, 2);
    chk("s5_no_poll", n_rd, 0);
    chk("s5_all_seen", exp_q.size(), 0);
    // reset during ACCESS
    do_reset();
    stuck = 1;
    start_pulse();
    k = 0;
    while (!penable && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("s6_reached_access", penable, 1);
    #2 rst = 1;
    #1;
    chk("s6_psel_async", psel, 0);
    chk("s6_penable_async", penable, 0);
    exp_q.delete();
    n_wr = 0;
    n_rd = 0;
    stuck = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("s6_no_resume_wr", n_wr, 0);
    chk("s6_no_resume_rd", n_rd, 0);
    chk("s6_idle_psel", psel, 0);
    match_at = 1;
    plan_init(1, -1);
    start_pulse();
    wait_init();
    chk("s6_done", init_done, 1);
    chk("s6_writes", n_wr, 2);
    chk("s6_reads", n_rd, 1);
    chk("s6_all_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serdes_apb_master.md
SERDES_APB_MASTER -- requirements
Module: serdes_apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, the maximum ACCESS-phase cycles waited for PREADY.
REQ-002 SHALL have parameter POLL_LIMIT, default 1024, the maximum status reads during the lock poll.
REQ-003 APB_M_PCLK  in  1  single clock; all logic on the rising edge.
REQ-004 APB_M_PRESET  in  1  asynchronous, active-high reset.
REQ-005 START  in  1  single-cycle pulse that launches the init sequence.
REQ-006 CMD_VALID/CMD_READY  in/out  1/1  user command handshake.
REQ-007 CMD_WRITE  in  1  1 = write, 0 = read.
REQ-008 CMD_ADDR  in  [13:2]  word address.
REQ-009 CMD_WDATA  in  [31:0]  write data.
REQ-010 RSP_VALID  out  1  one-cycle response strobe.
REQ-011 RSP_RDATA  out  [31:0]  read data (0 for writes).
REQ-012 RSP_ERR  out  1  PSLVERR or timeout.
REQ-013 INIT_DONE/INIT_FAIL  out  1/1  init outcome, sticky.
REQ-014 APB_M_PSEL/PENABLE/PWRITE  out  1 each  APB master controls.
REQ-015 APB_M_PADDR  out  [13:2];  APB_M_PWDATA  out  [31:0].
REQ-016 APB_M_PRDATA  in  [31:0];  APB_M_PREADY, APB_M_PSLVERR  in  1 each.

Function
REQ-017 FSM states: IDLE, SETUP, ACCESS, EVAL, READY.
REQ-018 IDLE: START=1 -> load init entry 0, mode INIT, go to SETUP; user commands are ignored (CMD_READY=0).
REQ-019 SETUP: PSEL=1, PENABLE=0, address/data/direction driven from the current entry; always advances to ACCESS after one cycle.
REQ-020 ACCESS: PSEL=1, PENABLE=1, outputs held stable; PREADY=1 -> capture PRDATA and PSLVERR, go to EVAL.
REQ-021 ACCESS timeout: when a wait counter reaches TIMEOUT-1 with PREADY=0, drop PSEL/PENABLE, flag error, go to EVAL.
REQ-022 Mode INIT: step through INIT_TABLE entries 0..INIT_LEN-1; an error on any entry -> INIT_FAIL=1, go to READY.
REQ-023 After the last entry, enter mode POLL: read POLL_ADDR repeatedly, back to back.
REQ-024 POLL succeeds when (PRDATA & POLL_MASK) == POLL_MASK -> INIT_DONE=1, go to READY.
REQ-025 POLL fails on an error, or when POLL_LIMIT reads complete without success -> INIT_FAIL=1, go to READY.
REQ-026 READY: CMD_READY=1; CMD_VALID & CMD_READY latches CMD_* and goes to SETUP in mode USER.
REQ-027 Mode USER EVAL: RSP_VALID=1 for one cycle with RSP_RDATA and RSP_ERR, then return to READY.
REQ-028 Command latency with PREADY tied high: handshake cycle plus 3 cycles (SETUP, ACCESS, EVAL) to RSP_VALID.
REQ-029 START pulses outside IDLE are ignored.
REQ-030 INIT_DONE and INIT_FAIL are mutually exclusive and clear only on reset.
REQ-031 Outside SETUP and ACCESS, PSEL=0 and PENABLE=0.
REQ-032 APB_M_PADDR and APB_M_PWDATA hold their last value when idle.
REQ-033 INIT_LEN = 0 skips directly to POLL.

Reset
REQ-034 Asserting APB_M_PRESET at any time, including mid-transfer, forces IDLE in the same cycle without waiting for a clock edge.
REQ-035 Reset values: all outputs 0, all counters 0.
REQ-036 No partial transfer resumes after reset is released.

Structure
REQ-037 Package serdes_apb_pkg SHALL hold the init entry type {write, addr[13:2], data[31:0]}, INIT_LEN, INIT_TABLE, POLL_ADDR, POLL_MASK, and the state enum.
REQ-038 Single module; no sub-module.

Verification
REQ-039 Scenario: INIT_TABLE = 2 writes (0x010 <= 0x1, 0x020 <= 0xA5), PREADY=1, status returns 0x1 on the 3rd poll -> exactly 2 writes then 3 reads on APB; INIT_DONE=1.
REQ-040 Scenario: status never matches, POLL_LIMIT=8 -> exactly 8 poll reads; INIT_FAIL=1; CMD_READY=1.
REQ-041 Scenario: user read at 0x100, slave inserts 3 wait states and returns 0xDEADBEEF -> RSP_VALID with RSP_RDATA=0xDEADBEEF, RSP_ERR=0; PADDR and PENABLE stable throughout.
REQ-042 Scenario: PREADY stuck at 0, TIMEOUT=16 -> PSEL drops after 16 ACCESS cycles; RSP_ERR=1.
REQ-043 Scenario: PSLVERR=1 on init entry 1 -> INIT_FAIL=1; no poll reads issued.
REQ-044 Scenario: reset asserted during ACCESS -> PSEL=0 immediately; after release, START reruns the sequence from entry 0.
